alu_64: RTL and testbench
=========================

Name: alu_64

Overview:
- 64-bit integer ALU for the 5-stage pipelined CPU's execute stage.
- Performs pass-through, add, subtract and bitwise logic on two 64-bit operands, selected by a 3-bit control code.
- Produces the result plus negative/zero/overflow/carry_out flags for the flag register and branch logic.
- Result and flags are registered: one clock of latency.

Parameters:
- WIDTH, 64, operand/result width; the flag definitions below refer to bit WIDTH-1 as the MSB.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- cntrl  input  3  operation select
- result  output  WIDTH  registered operation result
- negative  output  1  registered; equals result[WIDTH-1]
- zero  output  1  registered; 1 when result is all zeros
- overflow  output  1  registered; signed overflow on add/subtract
- carry_out  output  1  registered; carry out of the MSB on add/subtract

Behaviour:
- Operation codes:
  - 000: result = B
  - 001: result = A
  - 010: result = A + B
  - 011: result = A - B
  - 100: result = A & B
  - 101: result = A | B
  - 110: result = A ^ B
  - 111: result = A
- Add: full WIDTH-bit sum, modulo 2^WIDTH. carry_out = carry out of the MSB.
- Subtract: computed as A + ~B + 1. carry_out = 1 means no borrow (A >= B unsigned); carry_out = 0 means a borrow occurred.
- overflow (add and subtract) = carry into MSB XOR carry out of MSB. Equivalently, the operands' signs (after B inversion for subtract) agree and the result sign differs.
- For codes 000, 001, 100, 101, 110, 111: overflow = 0 and carry_out = 0.
- negative = result[WIDTH-1] and zero = (result == 0), evaluated on the value being registered, for every code.
- Timing:
  - The combinational datapath is computed from the current A, B and cntrl.
  - On each rising clk, result and all four flags are captured together.
  - Outputs for inputs applied before edge N are visible after edge N (latency 1, throughput 1 per cycle).
- Reset: asynchronous assertion immediately forces result = 0, negative = 0, zero = 1, overflow = 0, carry_out = 0.
  - Registers hold these values while reset is high.
  - The first capture happens on the first rising clk after deassertion.
  - A reset mid-stream discards the pending operation.
- No handshake; a new operation is accepted every cycle. A and B are unsigned bit vectors; signedness matters only for the negative and overflow flags.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_WIDTH = 64
  - cntrl encodings: ALU_PASS_B=3'b000, ALU_PASS_A=3'b001, ALU_ADD=3'b010, ALU_SUBTRACT=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110, ALU_PASS_A_ALT=3'b111
- Sub-module alu_bit_slice:
  - Inputs: one bit of A and B, carry-in, invert-B, cntrl.
  - Outputs: result bit and carry-out.
  - Instantiated WIDTH times in a ripple chain; carry-in of bit 0 = invert-B (1 for subtract).
- Top level holds the zero-detect reduction, the overflow XOR and the output register.

Test Plan:
- Reset: assert reset with A=B=1, cntrl=010 -> result=0, zero=1, negative=0, overflow=0, carry_out=0 immediately; after deassert and one clk -> result=2, all flags 0.
- Pass/logic: 100 random A,B for each code 000/001/111/100/101/110 -> after one clk, result equals B / A / A / A&B / A|B / A^B; negative=result[63]; zero=(result==0); overflow=carry_out=0.
- Add corners (values as top nibble, lower 60 bits zero):
  - F+8 -> 7, carry_out=1, overflow=1, negative=0, zero=0
  - 5+2 -> 7, carry_out=0, overflow=0
  - 8+8 -> 0, carry_out=1, overflow=1, zero=1
  - 7+1 -> 8, carry_out=0, overflow=1, negative=1
- Subtract corners (same encoding):
  - F-F -> 0, carry_out=1, overflow=0, zero=1
  - 8-F -> 9, carry_out=0, overflow=0, negative=1
  - 5-C -> 9, carry_out=0, overflow=1, negative=1
  - 7-2 -> 5, carry_out=1, overflow=0
- Random arithmetic: 50 random A,B each for 010 and 011 -> result equals A+B / A-B mod 2^64; flags consistent with the definitions above.
- Pipelining: change cntrl and operands every clk (ADD 1+1, SUB 3-5, XOR all-ones^0) -> outputs appear exactly one clk later, in order: 2; 0xFFFF_FFFF_FFFF_FFFE with negative=1, carry_out=0; all-ones with negative=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and control encodings for the 64-bit execute-stage ALU.
package alu_pkg;
   localparam int ALU_WIDTH = 64;

   localparam logic [2:0] ALU_PASS_B     = 3'b000;
   localparam logic [2:0] ALU_PASS_A     = 3'b001;
   localparam logic [2:0] ALU_ADD        = 3'b010;
   localparam logic [2:0] ALU_SUBTRACT   = 3'b011;
   localparam logic [2:0] ALU_AND        = 3'b100;
   localparam logic [2:0] ALU_OR         = 3'b101;
   localparam logic [2:0] ALU_XOR        = 3'b110;
   localparam logic [2:0] ALU_PASS_A_ALT = 3'b111;

   function automatic logic is_arith(input logic [2:0] c);
      return (c == ALU_ADD) || (c == ALU_SUBTRACT);
   endfunction
endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: full adder with optional B inversion plus bitwise ops.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   input  logic       inv_b_i,
   input  logic [2:0] cntrl_i,
   output logic       res_o,
   output logic       cout_o
);
   logic bx;
   logic sum;

   always_comb begin
      bx     = b_i ^ inv_b_i;
      sum    = a_i ^ bx ^ cin_i;
      cout_o = (a_i & bx) | (cin_i & (a_i ^ bx));
      res_o  = a_i;
      case (cntrl_i)
         ALU_PASS_B:                  res_o = b_i;
         ALU_ADD, ALU_SUBTRACT:       res_o = sum;
         ALU_AND:                     res_o = a_i & b_i;
         ALU_OR:                      res_o = a_i | b_i;
         ALU_XOR:                     res_o = a_i ^ b_i;
         default:                     res_o = a_i;
      endcase
   end
endmodule

// File: rtl/alu_64.sv
// Registered 64-bit ALU: ripple chain of bit slices, flag logic, output register.
module alu_64
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       cntrl,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);
   logic             inv_b;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] res_d, result_q;
   logic             arith;
   logic             neg_d, zero_d, ovf_d, cout_d;
   logic             neg_q, zero_q, ovf_q, cout_q;

   // Subtract is A + ~B + 1: the +1 enters as carry-in of bit 0.
   assign inv_b    = (cntrl == ALU_SUBTRACT);
   assign carry[0] = inv_b;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      alu_bit_slice u_slice (
         .a_i     (A[i]),
         .b_i     (B[i]),
         .cin_i   (carry[i]),
         .inv_b_i (inv_b),
         .cntrl_i (cntrl),
         .res_o   (res_d[i]),
         .cout_o  (carry[i+1])
      );
   end

   always_comb begin
      arith  = is_arith(cntrl);
      neg_d  = res_d[WIDTH-1];
      zero_d = (res_d == '0);
      ovf_d  = arith & (carry[WIDTH] ^ carry[WIDTH-1]);
      cout_d = arith & carry[WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         result_q <= res_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
      end
   end

   assign result    = result_q;
   assign negative  = neg_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;
   assign carry_out = cout_q;
endmodule

// File: tb/tb_alu_64.sv
// Scoreboard bench for alu_64: driver queues expected results, monitor checks one clk later.
module tb_alu_64;
   typedef struct {
      string       name;
      logic [63:0] r;
      logic        n, z, v, c;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] A, B;
   logic [2:0]  cntrl;
   logic [63:0] result;
   logic        negative, zero, overflow, carry_out;

   exp_t sbq[$];
   logic issue = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   alu_64 dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .cntrl(cntrl),
      .result(result), .negative(negative), .zero(zero),
      .overflow(overflow), .carry_out(carry_out)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input string nm, input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] c);
      exp_t e;
      logic [64:0] s;
      e.name = nm; e.v = 1'b0; e.c = 1'b0;
      case (c)
         3'b000: e.r = b;
         3'b010: begin
            s = {1'b0, a} + {1'b0, b};
            e.r = s[63:0]; e.c = s[64];
            e.v = (a[63] == b[63]) && (s[63] != a[63]);
         end
         3'b011: begin
            s = {1'b0, a} + {1'b0, ~b} + 65'd1;
            e.r = s[63:0]; e.c = s[64];
            e.v = (a[63] != b[63]) && (s[63] != a[63]);
         end
         3'b100: e.r = a & b;
         3'b101: e.r = a | b;
         3'b110: e.r = a ^ b;
         default: e.r = a;
      endcase
      e.n = e.r[63];
      e.z = (e.r == 64'd0);
      return e;
   endfunction

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [2:0] c,
                        input exp_t e);
      @(negedge clk);
      A = a; B = b; cntrl = c; issue = 1'b1;
      sbq.push_back(e);
   endtask

   task automatic drive_hand(input string nm, input logic [63:0] a, input logic [63:0] b,
                             input logic [2:0] c, input logic [63:0] r,
                             input logic n, input logic z, input logic v, input logic co);
      exp_t e;
      e.name = nm; e.r = r; e.n = n; e.z = z; e.v = v; e.c = co;
      drive(a, b, c, e);
   endtask

   task automatic chk_now(input string nm, input logic [63:0] r, input logic n, input logic z,
                          input logic v, input logic co);
      n_cmp++;
      if (result !== r || negative !== n || zero !== z || overflow !== v || carry_out !== co) begin
         n_bad++;
         $display("FAIL %s: got r=%h nzvc=%b%b%b%b want r=%h nzvc=%b%b%b%b", nm, result,
                  negative, zero, overflow, carry_out, r, n, z, v, co);
      end
   endtask

   // Monitor: every edge that captured an issued op gets checked against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (issue && !reset) begin
            #1;
            if (sbq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL underflow: output with no expected entry, got r=%h", result);
            end else begin
               e = sbq.pop_front();
               chk_now(e.name, e.r, e.n, e.z, e.v, e.c);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, got %0d compared want done", n_cmp);
      $fatal(1, "timeout");
   end

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [63:0] nib(input logic [3:0] x);
      return {x, 60'd0};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      logic [2:0] codes [6];
      logic [63:0] a, b;
      codes = '{3'b000, 3'b001, 3'b111, 3'b100, 3'b101, 3'b110};

      A = 64'd1; B = 64'd1; cntrl = 3'b010; reset = 1'b0;
      #1 reset = 1'b1;
      #1 chk_now("reset_async", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 chk_now("reset_hold", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      drive_hand("post_reset_add", 64'd1, 64'd1, 3'b010, 64'd2, 0, 0, 0, 0);

      drive_hand("add_F+8", nib(4'hF), nib(4'h8), 3'b010, nib(4'h7), 0, 0, 1, 1);
      drive_hand("add_5+2", nib(4'h5), nib(4'h2), 3'b010, nib(4'h7), 0, 0, 0, 0);
      drive_hand("add_8+8", nib(4'h8), nib(4'h8), 3'b010, 64'd0,     0, 1, 1, 1);
      drive_hand("add_7+1", nib(4'h7), nib(4'h1), 3'b010, nib(4'h8), 1, 0, 1, 0);
      drive_hand("sub_F-F", nib(4'hF), nib(4'hF), 3'b011, 64'd0,     0, 1, 0, 1);
      drive_hand("sub_8-F", nib(4'h8), nib(4'hF), 3'b011, nib(4'h9), 1, 0, 0, 0);
      drive_hand("sub_5-C", nib(4'h5), nib(4'hC), 3'b011, nib(4'h9), 1, 0, 1, 0);
      drive_hand("sub_7-2", nib(4'h7), nib(4'h2), 3'b011, nib(4'h5), 0, 0, 0, 1);
      drive_hand("and_zero", ONES, 64'd0, 3'b100, 64'd0, 0, 1, 0, 0);
      drive_hand("add_carry_ripple", ONES, 64'd1, 3'b010, 64'd0, 0, 1, 0, 1);

      // Back-to-back op changes: each result lands exactly one clk after issue.
      drive_hand("pipe_add", 64'd1, 64'd1, 3'b010, 64'd2, 0, 0, 0, 0);
      drive_hand("pipe_sub", 64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
      drive_hand("pipe_xor", ONES, 64'd0, 3'b110, ONES, 1, 0, 0, 0);

      for (int k = 0; k < 6; k++)
         for (int i = 0; i < 100; i++) begin
            a = rnd64(); b = rnd64();
            drive(a, b, codes[k], model($sformatf("logic_c%0d_%0d", codes[k], i), a, b, codes[k]));
         end
      for (int i = 0; i < 50; i++) begin
         a = rnd64(); b = rnd64();
         drive(a, b, 3'b010, model($sformatf("rnd_add_%0d", i), a, b, 3'b010));
         a = rnd64(); b = rnd64();
         drive(a, b, 3'b011, model($sformatf("rnd_sub_%0d", i), a, b, 3'b011));
      end

      @(negedge clk);
      issue = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
